// File: rtl/sram_pkg.sv
// Shared definitions for the 1RW write-masked SRAM model.
// Holds the read-pipeline depth limit, the per-stage tag struct and a
// clog2 helper that never returns 0, used for address-width checks.
package sram_pkg;

  localparam int unsigned MAX_READ_LATENCY = 4;

  // Control part of one read-pipeline stage; the data field is added by the
  // pipeline module, whose width is a module parameter.
  typedef struct packed {
    logic valid;
    logic err;
  } rd_tag_t;

  // Number of address bits needed for n words, at least 1.
  function automatic int unsigned clog2_safe(input int unsigned n);
    int unsigned r;
    for (r = 1; r < 32; r++) begin
      if ((32'd1 << r) >= n) break;
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// READ_LATENCY-deep read pipeline carrying {valid, err, data} per stage.
// Ports:
//   clk, rst_n            clock, async active-low reset (clears every stage)
//   req_valid/err/data    read issued at this edge (enters stage 0)
//   wr_err                out-of-range write at this edge (lands in the last stage)
//   data, valid, err      last-stage contents (registered)
module sram_rd_pipe
  import sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 512,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_err,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic                  wr_err,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  err
);

  localparam int unsigned LAST = READ_LATENCY - 1;

  typedef struct packed {
    rd_tag_t               tag;
    logic [DATA_WIDTH-1:0] data;
  } rd_stage_t;

  rd_stage_t stage_q    [READ_LATENCY];
  rd_stage_t stage_in_c [READ_LATENCY];

  assign stage_in_c[0] = '{tag: '{valid: req_valid, err: req_err}, data: req_data};

  for (genvar i = 1; i < READ_LATENCY; i++) begin : g_link
    assign stage_in_c[i] = stage_q[i-1];
  end

  for (genvar i = 0; i < READ_LATENCY; i++) begin : g_stage
    if (i < LAST) begin : g_mid
      // Intermediate stages shift unconditionally.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage_q[i] <= '0;
        else        stage_q[i] <= stage_in_c[i];
      end
    end else begin : g_last
      // Output stage: data only moves on a valid read so the output holds its
      // last read value; a write error strobes err without a valid.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stage_q[i] <= '0;
        end else begin
          stage_q[i].tag.valid <= stage_in_c[i].tag.valid;
          stage_q[i].tag.err   <= (stage_in_c[i].tag.valid & stage_in_c[i].tag.err) | wr_err;
          if (stage_in_c[i].tag.valid) stage_q[i].data <= stage_in_c[i].data;
        end
      end
    end
  end

  assign data  = stage_q[LAST].data;
  assign valid = stage_q[LAST].tag.valid;
  assign err   = stage_q[LAST].tag.err;

endmodule

// File: rtl/sram_1rw_wmask_pipe.sv
// Single-port SRAM model with per-segment write mask, non-power-of-two depth
// with out-of-range detection, and a configurable read pipeline.
// Ports:
//   clk0, rst0_n    clock, async active-low reset (control/outputs only, not the array)
//   csb0, web0      active-low chip select / write enable
//   addr0           word address; addr0 >= WORDS is out of range
//   wmask0, din0    write mask (one bit per WMASK_WIDTH segment) and write data
//   dout0, rvalid0  read data and its one-cycle valid strobe
//   err0            one-cycle strobe for a completed out-of-range access
module sram_1rw_wmask_pipe
  import sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 512,
  parameter int unsigned WORDS        = 45,
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned WMASK_WIDTH  = 8,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned VERBOSE      = 0
) (
  input  logic                              clk0,
  input  logic                              rst0_n,
  input  logic                              csb0,
  input  logic                              web0,
  input  logic [ADDR_WIDTH-1:0]             addr0,
  input  logic [DATA_WIDTH/WMASK_WIDTH-1:0] wmask0,
  input  logic [DATA_WIDTH-1:0]             din0,
  output logic [DATA_WIDTH-1:0]             dout0,
  output logic                              rvalid0,
  output logic                              err0
);

  localparam int unsigned NUM_WMASKS = DATA_WIDTH / WMASK_WIDTH;

  // Elaboration-time parameter checks.
  if (clog2_safe(WORDS) > ADDR_WIDTH || WORDS == 0) begin : g_chk_words
    $error("WORDS must be 1..2**ADDR_WIDTH");
  end
  if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_chk_mask
    $error("DATA_WIDTH must be a multiple of WMASK_WIDTH");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_chk_lat
    $error("READ_LATENCY must be 1..MAX_READ_LATENCY");
  end
  if (VERBOSE > 1) begin : g_chk_verbose
    $error("VERBOSE must be 0 or 1");
  end

  logic [DATA_WIDTH-1:0] mem [WORDS];

  logic                  in_range_c;
  logic                  wr_c;
  logic                  rd_c;
  logic [DATA_WIDTH-1:0] rd_word_c;

  // Compare one bit wider so WORDS == 2**ADDR_WIDTH does not wrap to 0.
  assign in_range_c = ({1'b0, addr0} < (ADDR_WIDTH+1)'(WORDS));
  assign wr_c       = ~csb0 & ~web0;
  assign rd_c       = ~csb0 &  web0;
  assign rd_word_c  = in_range_c ? mem[addr0] : '0;

  // Array write: masked segments only, suppressed when out of range.
  // The array is deliberately not reset.
  always_ff @(posedge clk0) begin
    if (wr_c && in_range_c) begin
      for (int unsigned s = 0; s < NUM_WMASKS; s++) begin
        if (wmask0[s]) mem[addr0][s*WMASK_WIDTH +: WMASK_WIDTH] <= din0[s*WMASK_WIDTH +: WMASK_WIDTH];
      end
    end
  end

  sram_rd_pipe #(
    .DATA_WIDTH   (DATA_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_rd_pipe (
    .clk       (clk0),
    .rst_n     (rst0_n),
    .req_valid (rd_c),
    .req_err   (~in_range_c),
    .req_data  (rd_word_c),
    .wr_err    (wr_c & ~in_range_c),
    .data      (dout0),
    .valid     (rvalid0),
    .err       (err0)
  );

endmodule

// File: tb/tb_sram_1rw_wmask_pipe.sv
// Scoreboard bench for sram_1rw_wmask_pipe: stimulus records the expected
// per-cycle outputs from a word-level memory model; a monitor compares them.
module tb_sram_1rw_wmask_pipe;

  localparam int unsigned DW    = 512;
  localparam int unsigned WORDS = 45;
  localparam int unsigned AW    = 6;
  localparam int unsigned MW    = 8;
  localparam int unsigned NM    = DW / MW;
  localparam int unsigned RL    = 3;

  logic          clk0 = 1'b0;
  logic          rst0_n;
  logic          csb0;
  logic          web0;
  logic [AW-1:0] addr0;
  logic [NM-1:0] wmask0;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout0;
  logic          rvalid0;
  logic          err0;

  sram_1rw_wmask_pipe #(
    .DATA_WIDTH   (DW),
    .WORDS        (WORDS),
    .ADDR_WIDTH   (AW),
    .WMASK_WIDTH  (MW),
    .READ_LATENCY (RL),
    .VERBOSE      (0)
  ) dut (
    .clk0    (clk0),
    .rst0_n  (rst0_n),
    .csb0    (csb0),
    .web0    (web0),
    .addr0   (addr0),
    .wmask0  (wmask0),
    .din0    (din0),
    .dout0   (dout0),
    .rvalid0 (rvalid0),
    .err0    (err0)
  );

  always #5 clk0 = ~clk0;

  // Number of rising edges so far.
  int cyc = 0;
  always @(posedge clk0) cyc <= cyc + 1;

  // Reference memory and scoreboard keyed by the edge count after which the
  // output must be visible.
  logic [DW-1:0] ref_mem [int];
  bit            exp_v   [int];
  bit            exp_err [int];
  logic [DW-1:0] exp_d   [int];
  logic [DW-1:0] held;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < int'(DW / 32); i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [NM-1:0] rand_mask();
    logic [NM-1:0] m;
    for (int i = 0; i < int'(NM / 32); i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  function automatic logic [DW-1:0] bit_mask(input logic [NM-1:0] m);
    logic [DW-1:0] b;
    for (int i = 0; i < int'(NM); i++) b[i*MW +: MW] = {MW{m[i]}};
    return b;
  endfunction

  // One request; the edge that samples it is cyc+1.
  task automatic do_op(input bit wr, input int a, input logic [NM-1:0] m, input logic [DW-1:0] d);
    int  k;
    bit  ok;
    logic [DW-1:0] b;
    @(negedge clk0);
    csb0   = 1'b0;
    web0   = ~wr;
    addr0  = AW'(a);
    wmask0 = m;
    din0   = d;
    k  = cyc + 1;
    ok = (a < int'(WORDS));
    if (wr) begin
      if (ok) begin
        b = bit_mask(m);
        ref_mem[a] = (ref_mem[a] & ~b) | (d & b);
      end else begin
        exp_err[k] = 1'b1;
      end
    end else begin
      exp_v[k+int'(RL)-1] = 1'b1;
      exp_d[k+int'(RL)-1] = ok ? ref_mem[a] : '0;
      if (!ok) exp_err[k+int'(RL)-1] = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk0);
      csb0   = 1'b1;
      web0   = 1'($urandom);
      addr0  = AW'($urandom);
      wmask0 = rand_mask();
      din0   = rand_word();
    end
  endtask

  // Reset between edges; in-flight results are dropped, memory kept.
  task automatic pulse_reset();
    @(negedge clk0);
    csb0 = 1'b1;
    #2 rst0_n = 1'b0;
    exp_v.delete();
    exp_err.delete();
    exp_d.delete();
    @(negedge clk0);
    @(negedge clk0);
    #2 rst0_n = 1'b1;
  endtask

  // Monitor: checks strobes and data every cycle against the scoreboard.
  always @(negedge clk0) begin
    bit ev;
    bit ee;
    if (!rst0_n) begin
      held = '0;
      n_cmp++;
      if (rvalid0 !== 1'b0 || err0 !== 1'b0 || dout0 !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs cyc=%0d: rvalid0=%b err0=%b dout0=%h, required all zero",
                 cyc, rvalid0, err0, dout0);
      end
    end else begin
      ev = exp_v.exists(cyc) ? exp_v[cyc] : 1'b0;
      ee = exp_err.exists(cyc) ? exp_err[cyc] : 1'b0;
      if (ev) held = exp_d[cyc];
      n_cmp++;
      if (rvalid0 !== ev || err0 !== ee) begin
        n_bad++;
        $display("FAIL strobes cyc=%0d: rvalid0=%b err0=%b, required rvalid0=%b err0=%b",
                 cyc, rvalid0, err0, ev, ee);
      end
      n_cmp++;
      if (dout0 !== held) begin
        n_bad++;
        $display("FAIL dout cyc=%0d: got %h required %h", cyc, dout0, held);
      end
    end
  end

  initial begin
    logic [DW-1:0] pat;
    rst0_n = 1'b0;
    csb0   = 1'b1;
    web0   = 1'b1;
    addr0  = '0;
    wmask0 = '0;
    din0   = '0;
    repeat (3) @(negedge clk0);
    #2 rst0_n = 1'b1;

    // Preload every valid word so the model never holds unknowns.
    for (int a = 0; a < int'(WORDS); a++) begin
      ref_mem[a] = '0;
      do_op(1'b1, a, '1, rand_word());
    end

    // Full-mask write then read.
    pat = {(DW/8){8'hA5}};
    do_op(1'b1, 3, '1, pat);
    do_op(1'b0, 3, '0, '0);
    idle(RL + 1);

    // Partial mask: only the low byte is cleared.
    do_op(1'b1, 7, '1, '1);
    do_op(1'b1, 7, NM'(1), '0);
    do_op(1'b0, 7, '0, '0);
    idle(RL + 1);

    // Back-to-back pipelined reads.
    do_op(1'b0, 0, '0, '0);
    do_op(1'b0, 1, '0, '0);
    do_op(1'b0, 2, '0, '0);
    idle(RL + 1);

    // Out-of-range write and read; neighbours must not be aliased.
    do_op(1'b1, 50, '1, rand_word());
    idle(1);
    do_op(1'b0, 50, '0, '0);
    do_op(1'b0, 5, '0, '0);
    do_op(1'b0, 18, '0, '0);
    do_op(1'b1, 63, '1, rand_word());
    do_op(1'b0, 44, '0, '0);
    do_op(1'b0, 45, '0, '0);
    idle(RL + 1);

    // Reset during an in-flight read; the earlier write survives.
    do_op(1'b1, 9, '1, rand_word());
    do_op(1'b0, 5, '0, '0);
    pulse_reset();
    idle(RL + 2);
    do_op(1'b0, 9, '0, '0);
    idle(RL + 1);

    // Write then immediate read, then idle cycles holding dout0.
    do_op(1'b1, 9, rand_mask(), rand_word());
    do_op(1'b0, 9, '0, '0);
    idle(RL + 4);

    // Random traffic with one mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      int r;
      int a;
      if (i == 200) pulse_reset();
      r = int'($urandom_range(0, 9));
      a = ($urandom_range(0, 99) < 85) ? int'($urandom_range(0, WORDS - 1))
                                       : int'($urandom_range(WORDS, 63));
      if (r < 3)      idle(1);
      else if (r < 6) do_op(1'b1, a, rand_mask(), rand_word());
      else            do_op(1'b0, a, '0, '0);
    end
    idle(RL + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
